// File: rtl/handshake_pkg.sv
// Shared helpers for the handshake fabric blocks.
// Holds the width helper and the legal range for NUM_INPUTS.
package handshake_pkg;

  localparam int MIN_NUM_INPUTS = 2;
  localparam int MAX_NUM_INPUTS = 16;

  // Number of bits needed to encode n values, never below 1.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/handshake_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above prio.
// Ports: req (requests), prio (pointer), grant (index), grant_valid.
module handshake_rr_arbiter
  import handshake_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] prio,
  output logic [W-1:0] grant,
  output logic         grant_valid
);

  localparam logic [W:0] NW = (W + 1)'(N);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [W:0]     off;
  logic [W:0]     sum;

  // rot[k] is the request of input (prio + k) mod N.
  assign dbl = {req, req} >> prio;
  assign rot = dbl[N-1:0];

  always_comb begin
    grant_valid = 1'b0;
    off = '0;
    // Scan downward so the smallest offset wins.
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        grant_valid = 1'b1;
        off = (W + 1)'(k);
      end
    end
    sum = {1'b0, prio} + off;
    if (sum >= NW) sum = sum - NW;
    grant = sum[W-1:0];
  end

endmodule

// File: rtl/handshake_rr_control_merge.sv
// Round-robin control merge: dataless tokens forked to outs and index.
// Ports: clk, rst (sync high), ins_valid/ins_ready, outs_*, index_*.
// Define HANDSHAKE_CMERGE_OREG_EN for a one-entry output register.
module handshake_rr_control_merge
  import handshake_pkg::*;
#(
  parameter int NUM_INPUTS  = 4,
  parameter int INDEX_WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_INPUTS-1:0]  ins_valid,
  output logic [NUM_INPUTS-1:0]  ins_ready,
  output logic                   outs_valid,
  input  logic                   outs_ready,
  output logic [INDEX_WIDTH-1:0] index,
  output logic                   index_valid,
  input  logic                   index_ready
);

  if (NUM_INPUTS < MIN_NUM_INPUTS || NUM_INPUTS > MAX_NUM_INPUTS) begin : g_bad_n
    $error("NUM_INPUTS out of range");
  end
  if (INDEX_WIDTH < clog2_min1(NUM_INPUTS)) begin : g_bad_w
    $error("INDEX_WIDTH too small for NUM_INPUTS");
  end

  localparam logic [INDEX_WIDTH-1:0] LAST = INDEX_WIDTH'(NUM_INPUTS - 1);

  logic [INDEX_WIDTH-1:0] prio;
  logic [INDEX_WIDTH-1:0] arb_grant;
  logic                   arb_valid;

  handshake_rr_arbiter #(
    .N(NUM_INPUTS),
    .W(INDEX_WIDTH)
  ) u_arb (
    .req        (ins_valid),
    .prio       (prio),
    .grant      (arb_grant),
    .grant_valid(arb_valid)
  );

`ifdef HANDSHAKE_CMERGE_OREG_EN

  logic                   oreg_valid;
  logic [INDEX_WIDTH-1:0] oreg_idx;
  logic                   sent_outs;
  logic                   sent_index;
  logic                   outs_fire;
  logic                   index_fire;
  logic                   drain;
  logic                   load;

  assign outs_valid  = ~rst & oreg_valid & ~sent_outs;
  assign index_valid = ~rst & oreg_valid & ~sent_index;
  assign index       = oreg_idx;

  assign outs_fire  = outs_valid & outs_ready;
  assign index_fire = index_valid & index_ready;

  // The held token leaves once both channels have taken it.
  assign drain = oreg_valid
               & (sent_outs | outs_fire)
               & (sent_index | index_fire);

  // Refill in the same cycle the held token drains.
  assign load = ~rst & arb_valid & (~oreg_valid | drain);

  assign ins_ready = load ? (NUM_INPUTS'(1) << arb_grant) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      prio       <= '0;
      oreg_valid <= 1'b0;
      oreg_idx   <= '0;
      sent_outs  <= 1'b0;
      sent_index <= 1'b0;
    end else if (load) begin
      oreg_valid <= 1'b1;
      oreg_idx   <= arb_grant;
      sent_outs  <= 1'b0;
      sent_index <= 1'b0;
      prio       <= (arb_grant == LAST) ? '0 : arb_grant + 1'b1;
    end else if (drain) begin
      oreg_valid <= 1'b0;
      sent_outs  <= 1'b0;
      sent_index <= 1'b0;
    end else begin
      sent_outs  <= sent_outs | outs_fire;
      sent_index <= sent_index | index_fire;
    end
  end

`else

  logic [INDEX_WIDTH-1:0] lock_idx;
  logic [INDEX_WIDTH-1:0] sel;
  logic                   locked;
  logic                   sent_outs;
  logic                   sent_index;
  logic                   present;
  logic                   outs_fire;
  logic                   index_fire;
  logic                   done_outs;
  logic                   done_index;
  logic                   complete;

  // A partly delivered token keeps its winner; readies never reach sel.
  assign sel     = locked ? lock_idx : arb_grant;
  assign present = ~rst & (locked | arb_valid);

  assign outs_valid  = present & ~sent_outs;
  assign index_valid = present & ~sent_index;
  assign index       = sel;

  assign outs_fire  = outs_valid & outs_ready;
  assign index_fire = index_valid & index_ready;
  assign done_outs  = sent_outs | outs_fire;
  assign done_index = sent_index | index_fire;
  assign complete   = present & done_outs & done_index;

  assign ins_ready = complete ? (NUM_INPUTS'(1) << sel) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      prio       <= '0;
      locked     <= 1'b0;
      lock_idx   <= '0;
      sent_outs  <= 1'b0;
      sent_index <= 1'b0;
    end else if (complete) begin
      locked     <= 1'b0;
      sent_outs  <= 1'b0;
      sent_index <= 1'b0;
      prio       <= (sel == LAST) ? '0 : sel + 1'b1;
    end else if (outs_fire | index_fire) begin
      locked     <= 1'b1;
      lock_idx   <= sel;
      sent_outs  <= done_outs;
      sent_index <= done_index;
    end
  end

  // Upstream must hold valid on the input whose token is half delivered.
  a_lock_hold : assert property (
    @(posedge clk) disable iff (rst) locked |-> ins_valid[lock_idx]
  );

`endif

endmodule
